serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first through
// one external 1-bit full adder and reassembles the sum with start/busy/done.
module serial_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] s_sh_d;
    logic             last_d;
    logic             in_run;

    assign in_run = (state_q == RUN);
    assign s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
    assign last_d = (cnt_q == CW'(WIDTH - 1));

    // The adder is held at all-zero inputs whenever no addition is in progress.
    assign fa_a   = in_run & a_sh_q[0];
    assign fa_b   = in_run & b_sh_q[0];
    assign fa_cin = in_run & carry_q;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_d) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a request; DONE lasts a single cycle.
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
